dram_arbiter: RTL and testbench

//  Shares the single-port 64x32 data RAM between the CPU load/store port and a

---
 rtl/dram_arbiter.sv | 121 ++++++++++++
 tb/tb_dram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// dram_arbiter
//   Shares the single-port data RAM between the CPU load/store port and the
//   host/debug port. The CPU has fixed priority, but a host that has lost
//   MAX_WAIT consecutive arbitrations wins the next one. Each access takes
//   three cycles (IDLE -> ISSUE -> DONE), and accesses never overlap.
//
// Ports
//   clk, rsta                      clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack             read data and one-cycle completion pulse
//   cpu_stall                      cpu_req & ~cpu_ack
//   host_req/we/addr/wdata         host request, held until host_ack
//   host_rdata, host_ack           read data and one-cycle completion pulse
//   mem_we/addr/wdata              RAM command, driven in ISSUE
//   mem_rdata                      synchronous RAM read data (1 cycle after addr)
//   busy                           an access is in flight
module dram_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rsta,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    state_t              state, state_nx;
    logic                owner_host;     // 0 = CPU owns the access in flight
    logic                lat_we;
    logic [3:0]          wait_cnt, wait_nx;
    logic                take;           // accept a new access this cycle
    logic                host_wins;
    logic                rd_done;
    logic [DATA_W-1:0]   cpu_rdata_q, host_rdata_q;

    // Arbitration and next state
    always_comb begin
        state_nx  = state;
        wait_nx   = wait_cnt;
        take      = 1'b0;
        host_wins = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req || host_req) begin
                    take      = 1'b1;
                    host_wins = host_req && (!cpu_req || wait_cnt == WAIT_MAX);
                    if (host_wins)
                        wait_nx = 4'd0;
                    else if (host_req && wait_cnt != WAIT_MAX)
                        wait_nx = wait_cnt + 4'd1;
                    state_nx = ISSUE;
                end
            end
            ISSUE:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // mem_addr/mem_wdata double as the latched request: they are loaded when
    // an access is accepted and simply hold until the next one.
    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) begin
            state        <= IDLE;
            wait_cnt     <= 4'd0;
            owner_host   <= 1'b0;
            lat_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
            if (take) begin
                owner_host <= host_wins;
                lat_we     <= host_wins ? host_we    : cpu_we;
                mem_addr   <= host_wins ? host_addr  : cpu_addr;
                mem_wdata  <= host_wins ? host_wdata : cpu_wdata;
            end
            if (rd_done && !owner_host) cpu_rdata_q  <= mem_rdata;
            if (rd_done &&  owner_host) host_rdata_q <= mem_rdata;
        end
    end

    // Write enable decoded from state so an asynchronous reset removes it at once.
    assign mem_we   = (state == ISSUE) && lat_we;
    assign busy     = (state != IDLE);
    assign cpu_ack  = (state == DONE) && !owner_host;
    assign host_ack = (state == DONE) &&  owner_host;
    assign rd_done  = (state == DONE) && !lat_we;

    // RAM data only arrives in DONE, so the ack cycle forwards it directly and
    // the holding register takes over from the next cycle.
    assign cpu_rdata  = (cpu_ack  && !lat_we) ? mem_rdata : cpu_rdata_q;
    assign host_rdata = (host_ack && !lat_we) ? mem_rdata : host_rdata_q;

    assign cpu_stall  = cpu_req && !cpu_ack;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter
//   Drives both ports against a behavioural RAM and compares every DUT output
//   each cycle with a transaction-level reference model, plus directed cases
//   with hand-computed expectations.
module tb_dram_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rsta = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack, cpu_stall;
    logic          host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic [DW-1:0] host_rdata;
    logic          host_ack;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int we_cnt = 0;
    int cack_cnt = 0;
    logic stall_at_hack = 1'b0;

    always #5 clk = ~clk;

    dram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .rsta(rsta),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    function automatic logic [31:0] init_val(input int a);
        return (32'(a) * 32'h0101_0101) ^ 32'hA5A5_0000;
    endfunction

    // Behavioural synchronous RAM, filled with a known pattern on the first edge
    logic [DW-1:0] ram [64];
    bit ram_init = 1'b0;
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 64; i++) ram[i] <= init_val(i);
            ram_init <= 1'b1;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(negedge clk) begin
        if (mem_we)  we_cnt   <= we_cnt + 1;
        if (cpu_ack) cack_cnt <= cack_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // ph: position within the current 3-cycle access (0 = free)
    int            ph = 0;
    int            wcnt = 0;
    bit            m_own = 1'b0;     // 1 = host
    bit            m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wd = '0;
    logic [DW-1:0] m_cpu_rd = '0, m_host_rd = '0;
    logic [DW-1:0] shadow [64];
    logic [63:0]   wr_mask = '0;
    logic          m_hw;

    function automatic logic [31:0] rdval(input logic [AW-1:0] a);
        return wr_mask[a] ? shadow[a] : init_val(int'(a));
    endfunction

    assign m_hw = host_req && (!cpu_req || wcnt == MW);

    always @(posedge clk or posedge rsta) begin
        if (rsta) begin
            ph <= 0; wcnt <= 0; m_own <= 1'b0; m_we <= 1'b0;
            m_addr <= '0; m_wd <= '0; m_cpu_rd <= '0; m_host_rd <= '0;
        end else begin
            case (ph)
                0: if (cpu_req || host_req) begin
                    m_own  <= m_hw;
                    m_we   <= m_hw ? host_we    : cpu_we;
                    m_addr <= m_hw ? host_addr  : cpu_addr;
                    m_wd   <= m_hw ? host_wdata : cpu_wdata;
                    if (m_hw) wcnt <= 0;
                    else if (host_req && wcnt < MW) wcnt <= wcnt + 1;
                    ph <= 1;
                end
                1: begin
                    if (m_we) begin
                        shadow[m_addr]  <= m_wd;
                        wr_mask[m_addr] <= 1'b1;
                    end
                    ph <= 2;
                end
                default: begin
                    if (!m_we) begin
                        if (m_own) m_host_rd <= rdval(m_addr);
                        else       m_cpu_rd  <= rdval(m_addr);
                    end
                    ph <= 0;
                end
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (ram_init) begin
            logic e_cack, e_hack;
            e_cack = (ph == 2) && !m_own;
            e_hack = (ph == 2) &&  m_own;
            chk("busy",       32'(busy),      32'(ph != 0));
            chk("mem_we",     32'(mem_we),    32'((ph == 1) && m_we));
            chk("mem_addr",   32'(mem_addr),  32'(m_addr));
            chk("mem_wdata",  mem_wdata,      m_wd);
            chk("cpu_ack",    32'(cpu_ack),   32'(e_cack));
            chk("host_ack",   32'(host_ack),  32'(e_hack));
            chk("cpu_rdata",  cpu_rdata,  (e_cack && !m_we) ? rdval(m_addr) : m_cpu_rd);
            chk("host_rdata", host_rdata, (e_hack && !m_we) ? rdval(m_addr) : m_host_rd);
            chk("cpu_stall",  32'(cpu_stall), 32'(cpu_req && !e_cack));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One access on one port; returns latency in cycles, read data and ack cycle
    task automatic access(input bit h, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input bit hold,
                          output int lat, output logic [DW-1:0] rd, output int ack_c);
        bit got;
        got = 1'b0; lat = 0; rd = '0; ack_c = -1;
        if (h) begin host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d; end
        else   begin cpu_req  = 1'b1; cpu_we  = we; cpu_addr  = a; cpu_wdata  = d; end
        while (!got && lat < 60) begin
            cyc();
            lat++;
            if (h ? host_ack : cpu_ack) begin
                got   = 1'b1;
                rd    = h ? host_rdata : cpu_rdata;
                ack_c = cyc_n;
                if (h) stall_at_hack = cpu_stall;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout port=%0d actual=no ack expected=ack within 60 cycles", h);
        end
        if (!hold || !got) begin
            if (h) host_req = 1'b0; else cpu_req = 1'b0;
        end
    endtask

    task automatic agent(input bit h, input int n);
        int gap, lat, ac;
        logic [DW-1:0] rd;
        logic [AW-1:0] a;
        bit we;
        for (int i = 0; i < n; i++) begin
            we  = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 4) == 0) ? 6'd63 : 6'($urandom_range(0, 7));
            gap = $urandom_range(0, 3);
            access(h, we, a, $urandom, (gap == 0) && (i < n - 1), lat, rd, ac);
            repeat (gap) cyc();
        end
    endtask

    initial begin
        int lat, ac, clat, hlat, cac, hac, w0, c0, bad;
        int cack [5];
        logic [DW-1:0] rd, crd, hrd;

        repeat (3) @(posedge clk);
        #1 rsta = 1'b0;

        // reset state
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_mem_we",32'(mem_we),  32'd0);
        chk("rst_addr",  32'(mem_addr),32'd0);
        chk("rst_wdata", mem_wdata,    32'd0);
        chk("rst_crd",   cpu_rdata,    32'd0);
        chk("rst_hrd",   host_rdata,   32'd0);

        // idle: nothing moves for 20 cycles
        bad = 0;
        repeat (20) begin
            cyc();
            if (busy || mem_we || cpu_ack || host_ack) bad++;
        end
        chk("idle_20", 32'(bad), 32'd0);

        // CPU write then read of address 5
        cyc();
        w0 = we_cnt;
        access(1'b0, 1'b1, 6'd5, 32'hDEAD_BEEF, 1'b0, lat, rd, ac);
        chk("t1_wr_lat", 32'(lat), 32'd2);
        chk("t1_we_cyc", 32'(we_cnt - w0), 32'd1);
        cyc();
        w0 = we_cnt;
        access(1'b0, 1'b0, 6'd5, 32'h0, 1'b0, lat, rd, ac);
        chk("t1_rd_lat", 32'(lat), 32'd2);
        chk("t1_rd_data", rd, 32'hDEAD_BEEF);
        chk("t1_rd_nowe", 32'(we_cnt - w0), 32'd0);

        // simultaneous requests, counter at zero: CPU first, host 3 cycles later
        cyc();
        fork
            access(1'b0, 1'b0, 6'd7, 32'h0,          1'b0, clat, crd, cac);
            access(1'b1, 1'b1, 6'd9, 32'h0BAD_F00D,  1'b0, hlat, hrd, hac);
        join
        chk("t2_cpu_lat",   32'(clat), 32'd2);
        chk("t2_host_gap",  32'(hac - cac), 32'd3);

        // CPU hammering: host wins the 5th arbitration, CPU regains right after
        cyc();
        fork
            for (int k = 0; k < 5; k++)
                access(1'b0, 1'(k % 2), 6'(10 + k), $urandom, k < 4, clat, crd, cack[k]);
            access(1'b1, 1'b0, 6'd20, 32'h0, 1'b0, hlat, hrd, hac);
        join
        chk("t3_host_lat",  32'(hlat), 32'd14);
        bad = 0;
        for (int k = 0; k < 5; k++) if (cack[k] < hac) bad++;
        chk("t3_cpu_before", 32'(bad), 32'd4);
        chk("t3_cpu_regain", 32'(cack[4] - hac), 32'd3);
        chk("t3_stall_host", 32'(stall_at_hack), 32'd1);

        // host write alone leaves the CPU side untouched
        cyc();
        c0 = cack_cnt;
        access(1'b1, 1'b1, 6'd63, 32'h1234_5678, 1'b0, hlat, hrd, hac);
        chk("t4_host_lat",   32'(hlat), 32'd2);
        chk("t4_no_cpu_ack", 32'(cack_cnt - c0), 32'd0);
        chk("t4_crd_hold",   cpu_rdata, init_val(14));
        cyc();
        access(1'b0, 1'b0, 6'd63, 32'h0, 1'b0, lat, rd, ac);
        chk("t4_rd63", rd, 32'h1234_5678);

        // reset during ISSUE of a CPU read
        cyc();
        c0 = cack_cnt;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5;
        cyc();
        chk("t5_in_issue", 32'(busy), 32'd1);
        rsta = 1'b1;
        #1;
        chk("t5_busy",   32'(busy),   32'd0);
        chk("t5_mem_we", 32'(mem_we), 32'd0);
        chk("t5_crd",    cpu_rdata,   32'd0);
        cpu_req = 1'b0;
        repeat (2) cyc();
        rsta = 1'b0;
        cyc();
        chk("t5_no_ack", 32'(cack_cnt - c0), 32'd0);
        access(1'b0, 1'b0, 6'd5, 32'h0, 1'b0, lat, rd, ac);
        chk("t5_lat",  32'(lat), 32'd2);
        chk("t5_data", rd, 32'hDEAD_BEEF);

        // randomized traffic on both ports
        cyc();
        fork
            agent(1'b0, 60);
            agent(1'b1, 60);
        join
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
